// File: rtl/arp_rx_pkg.sv
// Shared Ethernet/ARP constants and FSM state encoding for the ARP receive path.
package arp_rx_pkg;

   localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
   localparam logic [15:0] ARP_OP_REQ    = 16'h0001;
   localparam logic [15:0] ARP_OP_REP    = 16'h0002;
   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hd5;
   localparam logic [47:0] BROADCAST_MAC = 48'hff_ff_ff_ff_ff_ff;

   typedef enum logic [4:0] {
      st_idle     = 5'b00001,
      st_preamble = 5'b00010,
      st_eth_head = 5'b00100,
      st_arp_data = 5'b01000,
      st_rx_end   = 5'b10000
   } arp_rx_state_e;

endpackage

// File: rtl/arp_rx.sv
// GMII ARP receiver: parses preamble, Ethernet header and ARP payload, and reports
// sender MAC/IP plus opcode type for ARP frames addressed to this board.
module arp_rx
   import arp_rx_pkg::*;
#(
   parameter logic [47:0] BOARD_MAC = 48'ha0_b1_c2_d3_e1_e1,
   parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd11}
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        gmii_rx_dv,
   input  logic [7:0]  gmii_rxd,
   output logic        arp_rx_done,
   output logic        arp_rx_type,
   output logic [47:0] src_mac,
   output logic [31:0] src_ip
);

   arp_rx_state_e state_q;
   logic [4:0]    cnt_q;
   logic [47:0]   dmac_q;
   logic [15:0]   etype_q;
   logic [15:0]   op_q;
   logic [47:0]   smac_tmp_q;
   logic [31:0]   sip_tmp_q;
   logic [31:0]   tip_q;

   // Header/target checks happen on the last byte, so they see that byte combinationally.
   logic [15:0] etype_d;
   logic [31:0] tip_d;
   logic        dmac_ok;
   logic        op_ok;

   always_comb begin
      etype_d = {etype_q[7:0], gmii_rxd};
      tip_d   = {tip_q[23:0], gmii_rxd};
      dmac_ok = (dmac_q == BOARD_MAC) || (dmac_q == BROADCAST_MAC);
      op_ok   = (op_q == ARP_OP_REQ) || (op_q == ARP_OP_REP);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= st_idle;
         cnt_q       <= '0;
         dmac_q      <= '0;
         etype_q     <= '0;
         op_q        <= '0;
         smac_tmp_q  <= '0;
         sip_tmp_q   <= '0;
         tip_q       <= '0;
         arp_rx_done <= 1'b0;
         arp_rx_type <= 1'b0;
         src_mac     <= '0;
         src_ip      <= '0;
      end else begin
         arp_rx_done <= 1'b0;
         case (state_q)
            st_idle: begin
               if (gmii_rx_dv && gmii_rxd == PREAMBLE_BYTE) begin
                  state_q <= st_preamble;
                  cnt_q   <= 5'd1;
               end
            end
            st_preamble: begin
               if (!gmii_rx_dv) begin
                  state_q <= st_idle;
               end else if (cnt_q < 5'd7) begin
                  if (gmii_rxd == PREAMBLE_BYTE) cnt_q <= cnt_q + 5'd1;
                  else                           state_q <= st_rx_end;
               end else if (gmii_rxd == SFD_BYTE) begin
                  state_q <= st_eth_head;
                  cnt_q   <= '0;
               end else begin
                  state_q <= st_rx_end;
               end
            end
            st_eth_head: begin
               if (!gmii_rx_dv) begin
                  state_q <= st_idle;
               end else begin
                  cnt_q <= cnt_q + 5'd1;
                  if (cnt_q < 5'd6)   dmac_q  <= {dmac_q[39:0], gmii_rxd};
                  if (cnt_q >= 5'd12) etype_q <= etype_d;
                  if (cnt_q == 5'd13) begin
                     cnt_q   <= '0;
                     state_q <= (dmac_ok && etype_d == ETH_TYPE_ARP) ? st_arp_data : st_rx_end;
                  end
               end
            end
            st_arp_data: begin
               if (!gmii_rx_dv) begin
                  state_q <= st_idle;
               end else begin
                  cnt_q <= cnt_q + 5'd1;
                  if (cnt_q == 5'd6 || cnt_q == 5'd7)   op_q       <= {op_q[7:0], gmii_rxd};
                  if (cnt_q >= 5'd8 && cnt_q <= 5'd13)  smac_tmp_q <= {smac_tmp_q[39:0], gmii_rxd};
                  if (cnt_q >= 5'd14 && cnt_q <= 5'd17) sip_tmp_q  <= {sip_tmp_q[23:0], gmii_rxd};
                  if (cnt_q >= 5'd24)                   tip_q      <= tip_d;
                  if (cnt_q == 5'd27) begin
                     cnt_q   <= '0;
                     state_q <= st_rx_end;
                     if (tip_d == BOARD_IP && op_ok) begin
                        arp_rx_done <= 1'b1;
                        arp_rx_type <= (op_q == ARP_OP_REP);
                        src_mac     <= smac_tmp_q;
                        src_ip      <= sip_tmp_q;
                     end
                  end
               end
            end
            st_rx_end: begin
               if (!gmii_rx_dv) state_q <= st_idle;
            end
            default: state_q <= st_idle;
         endcase
      end
   end

endmodule

// File: tb/tb_arp_rx.sv
// Scoreboard bench for arp_rx: frames are built byte-wise, expected reports queued
// when the final payload byte is driven, and matched against each done pulse.
module tb_arp_rx;

   localparam logic [47:0] B_MAC = 48'ha0_b1_c2_d3_e1_e1;
   localparam logic [31:0] B_IP  = 32'hC0A8010B;
   localparam logic [47:0] BCAST = 48'hff_ff_ff_ff_ff_ff;

   logic        clk = 1'b0;
   logic        rst;
   logic        dv;
   logic [7:0]  rxd;
   logic        arp_rx_done;
   logic        arp_rx_type;
   logic [47:0] src_mac;
   logic [31:0] src_ip;

   arp_rx #(.BOARD_MAC(B_MAC), .BOARD_IP(B_IP)) dut (
      .clk        (clk),
      .rst        (rst),
      .gmii_rx_dv (dv),
      .gmii_rxd   (rxd),
      .arp_rx_done(arp_rx_done),
      .arp_rx_type(arp_rx_type),
      .src_mac    (src_mac),
      .src_ip     (src_ip)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        typ;
      logic [47:0] mac;
      logic [31:0] ip;
      logic [31:0] cyc;
   } exp_t;

   exp_t        sb[$];
   logic [7:0]  frm[$];
   logic [31:0] cyc = '0;
   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   logic        last_typ = 1'b0;
   logic [47:0] last_mac = '0;
   logic [31:0] last_ip  = '0;

   always @(posedge clk) cyc <= cyc + 32'd1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst === 1'b0 && arp_rx_done !== 1'b0) begin
         if (sb.size() == 0) begin
            check("spurious_done", {63'd0, arp_rx_done}, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("done_cycle", {32'd0, cyc}, {32'd0, e.cyc});
            check("done_type", {63'd0, arp_rx_type}, {63'd0, e.typ});
            check("done_mac", {16'd0, src_mac}, {16'd0, e.mac});
            check("done_ip", {32'd0, src_ip}, {32'd0, e.ip});
         end
      end
   end

   task automatic check_hold(input string tag);
      check({tag, "_type"}, {63'd0, arp_rx_type}, {63'd0, last_typ});
      check({tag, "_mac"}, {16'd0, src_mac}, {16'd0, last_mac});
      check({tag, "_ip"}, {32'd0, src_ip}, {32'd0, last_ip});
   endtask

   task automatic push_bytes(input logic [63:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) frm.push_back(v[i*8 +: 8]);
   endtask

   task automatic build(input logic [47:0] dst, input logic [15:0] et, input logic [15:0] op,
                        input logic [47:0] sha, input logic [31:0] spa, input logic [31:0] tpa,
                        input bit good_pre);
      frm.delete();
      for (int i = 0; i < (good_pre ? 7 : 6); i++) frm.push_back(8'h55);
      frm.push_back(8'hd5);
      push_bytes({16'd0, dst}, 6);
      push_bytes({16'd0, sha}, 6);
      push_bytes({48'd0, et}, 2);
      push_bytes(64'h0001_0800_0604, 6);
      push_bytes({48'd0, op}, 2);
      push_bytes({16'd0, sha}, 6);
      push_bytes({32'd0, spa}, 4);
      push_bytes(64'd0, 6);
      push_bytes({32'd0, tpa}, 4);
      for (int i = 0; i < 18; i++) frm.push_back(8'h00);
      push_bytes(64'hA5A5_A5A5, 4);
   endtask

   // Drives up to 'limit' bytes of frm, then exactly one dv=0 cycle.
   task automatic send(input int limit, input bit accept, input logic typ,
                       input logic [47:0] mac, input logic [31:0] ip);
      for (int i = 0; i < frm.size() && i < limit; i++) begin
         @(posedge clk); #1;
         dv  = 1'b1;
         rxd = frm[i];
         if (accept && i == 49) begin
            sb.push_back('{typ: typ, mac: mac, ip: ip, cyc: cyc + 32'd1});
            last_typ = typ;
            last_mac = mac;
            last_ip  = ip;
         end
      end
      @(posedge clk); #1;
      dv  = 1'b0;
      rxd = 8'h00;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      dv  = 1'b0;
      rxd = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check("reset_done", {63'd0, arp_rx_done}, 64'd0);
      check_hold("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      build(BCAST, 16'h0806, 16'h0001, 48'h001122334455, 32'hC0A80164, B_IP, 1'b1);
      send(999, 1'b1, 1'b0, 48'h001122334455, 32'hC0A80164);
      check_hold("t1");

      build(B_MAC, 16'h0806, 16'h0002, 48'h84A938BFC9A0, 32'hA9FE3378, B_IP, 1'b1);
      send(999, 1'b1, 1'b1, 48'h84A938BFC9A0, 32'hA9FE3378);
      check_hold("t2");

      build(BCAST, 16'h0806, 16'h0001, 48'h0A0B0C0D0E0F, 32'hC0A80199, 32'hC0A8010C, 1'b1);
      send(999, 1'b0, 1'b0, '0, '0);
      check_hold("rej_tip");
      build(48'h112233445566, 16'h0806, 16'h0001, 48'h0A0B0C0D0E0F, 32'hC0A80199, B_IP, 1'b1);
      send(999, 1'b0, 1'b0, '0, '0);
      check_hold("rej_dmac");
      build(B_MAC, 16'h0800, 16'h0001, 48'h0A0B0C0D0E0F, 32'hC0A80199, B_IP, 1'b1);
      send(999, 1'b0, 1'b0, '0, '0);
      check_hold("rej_etype");
      build(B_MAC, 16'h0806, 16'h0003, 48'h0A0B0C0D0E0F, 32'hC0A80199, B_IP, 1'b1);
      send(999, 1'b0, 1'b0, '0, '0);
      check_hold("rej_op");

      build(BCAST, 16'h0806, 16'h0001, 48'h0A0B0C0D0E0F, 32'hC0A80105, B_IP, 1'b0);
      send(999, 1'b0, 1'b0, '0, '0);
      check_hold("bad_pre");
      build(BCAST, 16'h0806, 16'h0001, 48'h0A0B0C0D0E0F, 32'hC0A80105, B_IP, 1'b1);
      send(999, 1'b1, 1'b0, 48'h0A0B0C0D0E0F, 32'hC0A80105);
      check_hold("after_pre");

      build(B_MAC, 16'h0806, 16'h0002, 48'h665544332211, 32'hC0A80177, B_IP, 1'b1);
      send(37, 1'b0, 1'b0, '0, '0);
      check_hold("abort");
      send(999, 1'b1, 1'b1, 48'h665544332211, 32'hC0A80177);
      check_hold("after_abort");

      build(BCAST, 16'h0806, 16'h0001, 48'hDEADBEEF0001, 32'hC0A80120, B_IP, 1'b1);
      for (int i = 0; i < 42; i++) begin
         @(posedge clk); #1;
         dv  = 1'b1;
         rxd = frm[i];
      end
      #2 rst = 1'b1;
      #1;
      last_typ = 1'b0;
      last_mac = '0;
      last_ip  = '0;
      check("rst_done", {63'd0, arp_rx_done}, 64'd0);
      check_hold("async_rst");
      @(posedge clk); #1;
      rst = 1'b0;
      dv  = 1'b0;
      rxd = 8'h00;
      @(posedge clk); #1;
      send(999, 1'b1, 1'b0, 48'hDEADBEEF0001, 32'hC0A80120);
      check_hold("after_rst");

      repeat (5) @(posedge clk);
      #1;
      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/arp_rx.md
Name: arp_rx

Overview:
- GMII-side ARP receiver; counterpart of the ARP transmitter.
- Parses incoming GMII bytes: preamble/SFD, Ethernet header, ARP payload.
- Accepts only ARP frames addressed to this board. Reports the sender MAC/IP and the ARP opcode type with a one-cycle done pulse.
- Feeds the ARP control logic, which decides whether to send a reply and caches the peer address for the UDP path.

Parameters:
- BOARD_MAC, 48'ha0_b1_c2_d3_e1_e1, local MAC address; frame destination must match this or broadcast.
- BOARD_IP, {8'd192,8'd168,8'd1,8'd11}, local IP; ARP target IP must match.

Ports:
- clk  in  1  GMII receive clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- gmii_rx_dv  in  1  GMII receive data valid.
- gmii_rxd  in  8  GMII receive data byte.
- arp_rx_done  out  1  one-cycle pulse: valid ARP frame for this board parsed.
- arp_rx_type  out  1  0 = ARP request (op 0x0001), 1 = ARP reply (op 0x0002).
- src_mac  out  48  sender hardware address from ARP payload.
- src_ip  out  32  sender protocol address from ARP payload.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset: all outputs 0, state st_idle, counters 0, capture registers 0.
- Input sampling: a byte is consumed only on cycles with gmii_rx_dv=1. Bytes with dv=0 inside a frame abort the frame (see below).
- FSM states: st_idle, st_preamble, st_eth_head, st_arp_data, st_rx_end.
- st_idle: dv=1 and rxd=8'h55 -> st_preamble, with preamble count = 1.
- st_preamble:
  - Preamble counts 1..6 must each receive 8'h55. Count 7 must receive 8'hd5, which moves to st_eth_head with cnt cleared.
  - Any other byte -> st_rx_end.
- st_eth_head, 14 bytes, cnt 0..13:
  - Bytes 0-5: destination MAC; must equal BOARD_MAC or 48'hff_ff_ff_ff_ff_ff.
  - Bytes 6-11: ignored.
  - Bytes 12-13: must equal 16'h0806.
  - Address and type are evaluated at byte 13, using the assembled header including byte 13. Pass -> st_arp_data. Fail -> st_rx_end.
- st_arp_data, 28 bytes, cnt 0..27:
  - Bytes 6-7: opcode, captured.
  - Bytes 8-13: shifted into a sender-MAC temp register.
  - Bytes 14-17: sender-IP temp register.
  - Bytes 24-27: target-IP temp register.
  - Bytes 0-5 and 18-23: not checked.
  - Evaluation happens at byte 27 (with byte 27 included). Acceptance requires target IP == BOARD_IP and opcode ∈ {0x0001, 0x0002}.
- Acceptance:
  - Cycle after byte 27 is sampled: arp_rx_done=1 for exactly one cycle.
  - In that same cycle, src_mac, src_ip and arp_rx_type take the new values.
  - Those outputs then hold until the next accepted frame.
  - Rejected frames leave the outputs unchanged and produce no done pulse.
  - After byte 27 the FSM enters st_rx_end regardless of pass/fail.
- st_rx_end: discards padding and FCS (no CRC check in this block). Remains until dv=0, then -> st_idle.
- Abort:
  - dv=0 in st_preamble, st_eth_head or st_arp_data -> st_idle directly, with no done.
  - Temp registers are overwritten on the next frame; no explicit clear is needed.
- Back-to-back frames: st_rx_end -> st_idle takes one dv=0 cycle. A preamble starting on the very next dv=1 cycle is accepted.
- Reset mid-frame: immediate return to reset state. A partial frame still on the wire after reset is only accepted if its remaining bytes happen to start with 8'h55 from st_idle; the bench treats it as a don't-care.
- Counter width: 5 bits is sufficient (max 27).

Decomposition:
- Shared eth package: ETH_TYPE_ARP=16'h0806, ARP_OP_REQ=16'h0001, ARP_OP_REP=16'h0002, PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hd5, BROADCAST_MAC, and the one-hot state encodings.
- No sub-module: a single FSM plus capture registers.

Test Plan:
1. Broadcast request, sender 00_11_22_33_44_55 / 192.168.1.100, target 192.168.1.11 -> one arp_rx_done pulse the cycle after payload byte 27; arp_rx_type=0; src_mac=48'h001122334455; src_ip=32'hC0A80164.
2. Unicast reply to BOARD_MAC, op 0x0002, sender 84_A9_38_BF_C9_A0 / 169.254.51.120 -> done pulse; arp_rx_type=1; src_ip=32'hA9FE3378.
3. Frames that must be rejected, each with outputs unchanged from the previous case and no done:
   - target IP 192.168.1.12;
   - dest MAC 11_22_33_44_55_66;
   - eth type 0x0800;
   - opcode 0x0003.
4. Bad preamble (six 0x55 then 0xd5), then a valid frame after one idle cycle -> no done for the first, done for the second.
5. dv dropped at payload byte 15, then a valid frame -> no done for the first, done with correct values for the second.
6. rst asserted mid st_arp_data -> all outputs 0 immediately (async); a following valid request -> correct done and values.
